// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and default sizing.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } meter_state_t;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_AVG_LOG2 = 2;
  localparam int DEF_TIMEOUT  = 65535;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge detector.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic level,
  output logic rise
);

  logic sync1, sync2, sync3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sig;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign level = sync2;
  assign rise  = sync2 & ~sync3;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous clock, averaged over 2^AVG_LOG2 periods, in clk_in cycles.
// Defining CLK_PERIOD_METER_DUTY_EN adds meas_high, the averaged high time of the same periods.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_period,
`ifdef CLK_PERIOD_METER_DUTY_EN
  output logic [CNT_W-1:0] meas_high,
`endif
  output logic             meas_timeout
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int EC_W  = AVG_LOG2 + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [EC_W-1:0]  EC_LAST = EC_W'((1 << AVG_LOG2) - 1);

  meter_state_t     state, state_nxt;
  logic             level, rise;
  logic [ACC_W-1:0] tot;
  logic [EC_W-1:0]  edge_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic             to_hit, done_ok, done_to;
  logic [ACC_W:0]   tot_inc;
  logic [ACC_W-1:0] tot_sat;
  logic [CNT_W-1:0] period_calc;

  sync_edge_det u_sync (
    .clk  (clk_in),
    .rst_n(rst_n),
    .sig  (sig_in),
    .level(level),
    .rise (rise)
  );

  // The closing edge cycle itself belongs to the window, hence tot+1.
  assign tot_inc     = {1'b0, tot} + 1'b1;
  assign tot_sat     = (tot == ACC_MAX) ? tot : tot_inc[ACC_W-1:0];
  assign period_calc = (tot == ACC_MAX) ? '1 : CNT_W'(tot_inc >> AVG_LOG2);
  assign to_hit      = (to_cnt == TO_LAST);
  assign busy        = (state != IDLE);
  assign meas_valid  = (state == DONE);

  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ARM;
      ARM: begin
        if (rise) begin
          state_nxt = MEAS;
        end else if (to_hit) begin
          done_to   = 1'b1;
          state_nxt = DONE;
        end
      end
      MEAS: begin
        if (rise) begin
          if (edge_cnt == EC_LAST) begin
            done_ok   = 1'b1;
            state_nxt = DONE;
          end
        end else if (to_hit) begin
          done_to   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    if (meas_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      tot          <= '0;
      edge_cnt     <= '0;
      to_cnt       <= '0;
      meas_period  <= '0;
      meas_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tot      <= '0;
            edge_cnt <= '0;
            to_cnt   <= '0;
          end
        end
        ARM: begin
          if (rise) begin
            tot      <= '0;
            edge_cnt <= '0;
            to_cnt   <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        MEAS: begin
          tot <= tot_sat;
          if (rise) begin
            to_cnt   <= '0;
            edge_cnt <= edge_cnt + 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (done_ok) begin
        meas_period  <= period_calc;
        meas_timeout <= 1'b0;
      end else if (done_to) begin
        meas_period  <= '0;
        meas_timeout <= 1'b1;
      end
    end
  end

`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [ACC_W-1:0] hi_acc, hi_sat;

  // Like tot, the closing edge cycle's high sample is included in the result.
  assign hi_sat = (hi_acc == ACC_MAX) ? hi_acc : hi_acc + ACC_W'(level);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      hi_acc    <= '0;
      meas_high <= '0;
    end else begin
      if ((state == IDLE && start) || (state == ARM && rise)) hi_acc <= '0;
      else if (state == MEAS)                                  hi_acc <= hi_sat;
      if (done_ok)      meas_high <= CNT_W'(hi_sat >> AVG_LOG2);
      else if (done_to) meas_high <= '0;
    end
  end
`else
  logic unused_level;
  assign unused_level = level;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: two instances (4-period and single-period averaging)
// share one randomized sig_in; expectations come from recorded rise times. Honours CLK_PERIOD_METER_DUTY_EN.
module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int TO    = 100;

  logic             clk_in = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic             start = 1'b0;
  logic             ready2 = 1'b0, ready0 = 1'b0;
  logic             busy2, busy0, valid2, valid0, to2, to0;
  logic [CNT_W-1:0] per2, per0;
`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] high2, high0;
`endif

  clk_period_meter #(.CNT_W(CNT_W), .AVG_LOG2(2), .TIMEOUT(TO)) dut_a2 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start),
    .busy(busy2), .meas_valid(valid2), .meas_ready(ready2), .meas_period(per2),
`ifdef CLK_PERIOD_METER_DUTY_EN
    .meas_high(high2),
`endif
    .meas_timeout(to2)
  );

  clk_period_meter #(.CNT_W(CNT_W), .AVG_LOG2(0), .TIMEOUT(TO)) dut_a0 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start),
    .busy(busy0), .meas_valid(valid0), .meas_ready(ready0), .meas_period(per0),
`ifdef CLK_PERIOD_METER_DUTY_EN
    .meas_high(high0),
`endif
    .meas_timeout(to0)
  );

  always #5 clk_in = ~clk_in;

  // Posedge index, every sampled sig_in value, and the posedge of each sampled rise.
  int cyc = 0;
  int rises[$];
  bit hist[$];
  bit sig_prev = 1'b0;

  initial forever begin
    @(posedge clk_in);
    hist.push_back(sig_in);
    if (sig_in && !sig_prev) rises.push_back(cyc);
    sig_prev = sig_in;
    cyc++;
  end

  // Waveform source: 0 = held low, 1 = fixed period/high, 2 = random period and high per cycle.
  int mode = 0, fix_len = 16, fix_hi = 8, rmin = 4, rmax = 40;
  int cur_len = 1, cur_hi = 0, ph = 0;

  initial forever begin
    @(negedge clk_in);
    if (mode == 0) begin
      sig_in = 1'b0;
      ph = 0;
    end else begin
      if (ph == 0) begin
        if (mode == 1) begin
          cur_len = fix_len;
          cur_hi  = fix_hi;
        end else begin
          cur_len = $urandom_range(rmax, rmin);
          cur_hi  = $urandom_range(cur_len - 1, 1);
        end
      end
      sig_in = (ph < cur_hi);
      ph = (ph + 1 == cur_len) ? 0 : ph + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference: a rise sampled at posedge r is acted on at posedge r+2. After start sampled at s,
  // the first such edge opens the window, 2^avg further edges close it; any gap over TO aborts.
  function automatic void model(input int s, input int avg, output int done, output bit tmo,
                                output int per, output int high);
    int n = 1 << avg;
    int k = 0;
    int last = s;
    int a0 = 0;
    tmo = 1'b1;
    per = 0;
    high = 0;
    foreach (rises[i]) begin
      int a;
      a = rises[i] + 2;
      if (a <= s) continue;
      if (a - last > TO) break;
      if (k == 0) a0 = a;
      k++;
      last = a;
      if (k == n + 1) begin
        tmo = 1'b0;
        done = a;
        per = (a - a0) >> avg;
        for (int c = a0 - 1; c <= a - 2; c++) high += int'(hist[c]);
        high = high >> avg;
        return;
      end
    end
    done = last + TO;
  endfunction

  int last_s, last_d2, last_d0;
  logic [CNT_W-1:0] last_p2, last_p0, last_h2, last_h0;
  logic last_t2, last_t0;

  // One measurement on both instances: start, await both results, check, hold, then accept.
  task automatic applyStimulus(input bit noisy, input int hold);
    int s, d2, d0, e_d2, e_d0, e_p2, e_p0, e_h2, e_h0;
    bit e_t2, e_t0;
    d2 = -1;
    d0 = -1;
    @(negedge clk_in);
    start = 1'b1;
    s = cyc;
    @(negedge clk_in);
    start = 1'b0;
    checkOutput("busy_after_start", {busy2, busy0}, 2'b11);
    for (int i = 0; i < 1500 && (d2 < 0 || d0 < 0); i++) begin
      if (noisy) start = ($urandom_range(5, 0) == 0);
      @(negedge clk_in);
      if (valid2 && d2 < 0) begin
        d2 = cyc - 1; last_p2 = per2; last_t2 = to2;
`ifdef CLK_PERIOD_METER_DUTY_EN
        last_h2 = high2;
`endif
      end
      if (valid0 && d0 < 0) begin
        d0 = cyc - 1; last_p0 = per0; last_t0 = to0;
`ifdef CLK_PERIOD_METER_DUTY_EN
        last_h0 = high0;
`endif
      end
    end
    start = 1'b0;
    checkOutput("valid_within_bound", {d2 >= 0, d0 >= 0}, 2'b11);
    model(s, 2, e_d2, e_t2, e_p2, e_h2);
    model(s, 0, e_d0, e_t0, e_p0, e_h0);
    checkOutput("done_cycle_avg4", d2, e_d2);
    checkOutput("done_cycle_avg1", d0, e_d0);
    checkOutput("timeout_avg4", last_t2, e_t2);
    checkOutput("timeout_avg1", last_t0, e_t0);
    checkOutput("period_avg4", last_p2, e_p2);
    checkOutput("period_avg1", last_p0, e_p0);
`ifdef CLK_PERIOD_METER_DUTY_EN
    checkOutput("high_avg4", last_h2, e_h2);
    checkOutput("high_avg1", last_h0, e_h0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_in);
      checkOutput("hold_valid", {valid2, valid0}, 2'b11);
      checkOutput("hold_period_avg4", per2, e_p2);
      checkOutput("hold_timeout_avg4", to2, e_t2);
    end
    ready2 = 1'b1;
    ready0 = 1'b1;
    if (noisy) start = 1'b1;
    @(negedge clk_in);
    ready2 = 1'b0;
    ready0 = 1'b0;
    start = 1'b0;
    checkOutput("idle_after_ready", {busy2, busy0, valid2, valid0}, 4'b0000);
    checkOutput("period_kept_avg4", per2, e_p2);
    last_s = s;
    last_d2 = d2;
    last_d0 = d0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    checkOutput("reset_busy", {busy2, busy0}, 2'b00);
    checkOutput("reset_valid", {valid2, valid0}, 2'b00);
    checkOutput("reset_period", {per2, per0}, 32'd0);
    checkOutput("reset_timeout", {to2, to0}, 2'b00);
`ifdef CLK_PERIOD_METER_DUTY_EN
    checkOutput("reset_high", {high2, high0}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);

    // Divide-by-16 clock.
    mode = 1; fix_len = 16; fix_hi = 8;
    repeat (3) @(negedge clk_in);
    applyStimulus(1'b0, 0);
    checkOutput("div16_period_avg4", last_p2, 16);
    checkOutput("div16_period_avg1", last_p0, 16);
    checkOutput("div16_timeout", last_t2, 1'b0);

    // Period 10, high 3, with the consumer stalling 20 cycles.
    fix_len = 10; fix_hi = 3;
    repeat (40) @(negedge clk_in);
    applyStimulus(1'b0, 20);
    checkOutput("p10_period_avg1", last_p0, 10);
    checkOutput("p10_period_avg4", last_p2, 10);
`ifdef CLK_PERIOD_METER_DUTY_EN
    checkOutput("p10_high_avg1", last_h0, 3);
    checkOutput("p10_high_avg4", last_h2, 3);
`endif

    // sig_in held low: abort exactly TO cycles after ARM entry.
    mode = 0;
    repeat (8) @(negedge clk_in);
    applyStimulus(1'b0, 0);
    checkOutput("stuck_latency", last_d2 - last_s, TO);
    checkOutput("stuck_timeout", {last_t2, last_t0}, 2'b11);
    checkOutput("stuck_period", last_p2, 0);

    // Reset in the middle of a measurement, then a clean re-measure.
    mode = 1; fix_len = 16; fix_hi = 8;
    repeat (40) @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    repeat (40) @(negedge clk_in);
    checkOutput("pre_reset_busy_avg4", busy2, 1'b1);
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    checkOutput("midreset_busy", {busy2, busy0}, 2'b00);
    checkOutput("midreset_valid", {valid2, valid0}, 2'b00);
    checkOutput("midreset_period", {per2, per0}, 32'd0);
    repeat (6) @(negedge clk_in);
    applyStimulus(1'b0, 0);
    checkOutput("after_reset_period", last_p2, 16);

    // Stray start pulses while busy must not disturb the result.
    applyStimulus(1'b1, 3);
    checkOutput("noisy_period_avg4", last_p2, 16);
    checkOutput("noisy_period_avg1", last_p0, 16);

    // Jittery waveforms, some slow enough to abort mid-measurement.
    mode = 2;
    for (int r = 0; r < 12; r++) begin
      rmin = $urandom_range(8, 3);
      rmax = rmin + $urandom_range((r % 3 == 2) ? 110 : 40, 0);
      repeat ($urandom_range(30, 1)) @(negedge clk_in);
      applyStimulus(1'($urandom_range(1, 0)), $urandom_range(3, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
